// File: rtl/cpu_pkg.sv
// cpu_pkg - shared types and constants for the 16-bit accumulator/register CPU.
// Imported by the control unit, the opcode decoder and the datapath.
//   opcode_e     : IR[15:12] opcode values
//   state_e      : control FSM states (also exported on the debug port)
//   alu_op_e     : ALU operation select
//   pc_sel_e     : PC next-value source
//   alu_b_sel_e  : ALU B operand source
//   instr_class_t: one-hot-ish instruction class produced by opcode_decode
package cpu_pkg;

    localparam int IR_W      = 16;
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;
    localparam int RD_MSB    = 11;
    localparam int RD_LSB    = 9;
    localparam int RS1_MSB   = 8;
    localparam int RS1_LSB   = 6;
    localparam int RS2_MSB   = 5;
    localparam int RS2_LSB   = 3;
    localparam int IMM6_MSB  = 5;
    localparam int IMM9_MSB  = 8;
    localparam int IMM12_MSB = 11;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_ADDI = 4'h5,
        OP_LDI  = 4'h6,
        OP_LD   = 4'h7,
        OP_ST   = 4'h8,
        OP_BEQ  = 4'h9,
        OP_JMP  = 4'hA,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_BRANCH = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_OR     = 3'd3,
        ALU_PASS_B = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SEL_INC    = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_JUMP   = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        B_SEL_REG  = 2'd0,
        B_SEL_SE1  = 2'd1,
        B_SEL_SE2  = 2'd2
    } alu_b_sel_e;

    typedef struct packed {
        logic is_alu;
        logic is_alui;
        logic is_ldi;
        logic is_ld;
        logic is_st;
        logic is_beq;
        logic is_jmp;
        logic is_halt;
        logic is_nop;
    } instr_class_t;

endpackage

// File: rtl/cpu_control_opcode_decode.sv
// opcode_decode - combinational opcode to instruction-class decoder.
//   opcode : IR[15:12]
//   cls    : instruction class flags (exactly one set)
//   alu_op : ALU operation for register-register ALU instructions
module opcode_decode
    import cpu_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opcode,
    output instr_class_t     cls,
    output alu_op_e          alu_op
);

    always_comb begin
        cls    = '0;
        alu_op = ALU_ADD;
        case (opcode_e'(opcode))
            OP_ADD:  begin cls.is_alu = 1'b1; alu_op = ALU_ADD; end
            OP_SUB:  begin cls.is_alu = 1'b1; alu_op = ALU_SUB; end
            OP_AND:  begin cls.is_alu = 1'b1; alu_op = ALU_AND; end
            OP_OR:   begin cls.is_alu = 1'b1; alu_op = ALU_OR;  end
            OP_ADDI: cls.is_alui = 1'b1;
            OP_LDI:  cls.is_ldi  = 1'b1;
            OP_LD:   cls.is_ld   = 1'b1;
            OP_ST:   cls.is_st   = 1'b1;
            OP_BEQ:  cls.is_beq  = 1'b1;
            OP_JMP:  cls.is_jmp  = 1'b1;
            OP_HALT: cls.is_halt = 1'b1;
            // NOP and the unassigned opcodes B..E
            default: cls.is_nop  = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// cpu_control - multi-cycle control FSM for the 16-bit accumulator/register CPU.
//
// state  | meaning
// IDLE   | stopped, waiting for run
// FETCH  | IR <= imem[PC], PC <= PC+1
// DECODE | A/B <= regfile, opcode latched for the rest of the instruction
// EXEC   | ALU operation, address calculation or jump
// MEM    | data-memory access, held until mem_ready
// WB     | register-file write from ACC or MDR
// BRANCH | conditional PC <= PC+se_2 when flag_z
// HALT   | absorbing stop, left only through rst
//
// Ports: clk, rst (sync active-high), run, opcode (IR[15:12]), flag_z,
// mem_ready in; datapath strobes/selects, halted and debug state out.
module cpu_control
    import cpu_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    input  logic             flag_z,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             ir_we,
    output logic             a_we,
    output logic             b_we,
    output logic [2:0]       alu_op,
    output logic [1:0]       alu_b_sel,
    output logic             acc_we,
    output logic             flags_we,
    output logic             mar_we,
    output logic             mdr_we,
    output logic             mem_req,
    output logic             ram_we,
    output logic             rf_we,
    output logic             rf_wsel,
    output logic             halted,
    output logic [2:0]       state
);

    state_e           state_q;
    state_e           state_d;
    logic [OPC_W-1:0] opc_q;
    logic [OPC_W-1:0] dec_opc;
    instr_class_t     cls;
    alu_op_e          dec_alu_op;

    // The IR is loaded at the end of FETCH, so DECODE sees the live opcode;
    // later states use the copy taken in DECODE so IR changes are ignored.
    assign dec_opc = (state_q == ST_DECODE) ? opcode : opc_q;

    opcode_decode #(.OPC_W(OPC_W)) u_dec (
        .opcode (dec_opc),
        .cls    (cls),
        .alu_op (dec_alu_op)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                opc_q <= opcode;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_INC;
        ir_we     = 1'b0;
        a_we      = 1'b0;
        b_we      = 1'b0;
        alu_op    = ALU_ADD;
        alu_b_sel = B_SEL_REG;
        acc_we    = 1'b0;
        flags_we  = 1'b0;
        mar_we    = 1'b0;
        mdr_we    = 1'b0;
        mem_req   = 1'b0;
        ram_we    = 1'b0;
        rf_we     = 1'b0;
        rf_wsel   = 1'b0;
        halted    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = PC_SEL_INC;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                a_we = 1'b1;
                b_we = 1'b1;
                if (cls.is_nop) begin
                    state_d = ST_FETCH;
                end else if (cls.is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (cls.is_alu) begin
                    alu_op    = dec_alu_op;
                    alu_b_sel = B_SEL_REG;
                    acc_we    = 1'b1;
                    flags_we  = 1'b1;
                    state_d   = ST_WB;
                end else if (cls.is_alui) begin
                    alu_op    = ALU_ADD;
                    alu_b_sel = B_SEL_SE1;
                    acc_we    = 1'b1;
                    flags_we  = 1'b1;
                    state_d   = ST_WB;
                end else if (cls.is_ldi) begin
                    alu_op    = ALU_PASS_B;
                    alu_b_sel = B_SEL_SE2;
                    acc_we    = 1'b1;
                    state_d   = ST_WB;
                end else if (cls.is_ld || cls.is_st) begin
                    alu_op    = ALU_ADD;
                    alu_b_sel = B_SEL_SE1;
                    mar_we    = 1'b1;
                    state_d   = ST_MEM;
                end else if (cls.is_beq) begin
                    alu_op    = ALU_SUB;
                    alu_b_sel = B_SEL_REG;
                    flags_we  = 1'b1;
                    state_d   = ST_BRANCH;
                end else if (cls.is_jmp) begin
                    pc_we     = 1'b1;
                    pc_sel    = PC_SEL_JUMP;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                ram_we  = cls.is_st;
                if (mem_ready) begin
                    if (cls.is_ld) begin
                        mdr_we  = 1'b1;
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                rf_wsel = cls.is_ld;
                state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                pc_sel  = PC_SEL_BRANCH;
                pc_we   = flag_z;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control - directed-vector bench for cpu_control.
module tb_cpu_control;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       flag_z = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_we, ir_we, a_we, b_we, acc_we, flags_we, mar_we, mdr_we;
    logic       mem_req, ram_we, rf_we, rf_wsel, halted;
    logic [1:0] pc_sel, alu_b_sel;
    logic [2:0] alu_op, state;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_control #(.OPC_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .opcode    (opcode),
        .flag_z    (flag_z),
        .mem_ready (mem_ready),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .ir_we     (ir_we),
        .a_we      (a_we),
        .b_we      (b_we),
        .alu_op    (alu_op),
        .alu_b_sel (alu_b_sel),
        .acc_we    (acc_we),
        .flags_we  (flags_we),
        .mar_we    (mar_we),
        .mdr_we    (mdr_we),
        .mem_req   (mem_req),
        .ram_we    (ram_we),
        .rf_we     (rf_we),
        .rf_wsel   (rf_wsel),
        .halted    (halted),
        .state     (state)
    );

    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {pc_we, pc_sel, ir_we, a_we, b_we, alu_op, alu_b_sel, acc_we,
                  flags_we, mar_we, mdr_we, mem_req, ram_we, rf_we, rf_wsel, halted};

    function automatic logic [19:0] ov(
        input logic pcw, input logic [1:0] pcs, input logic irw, input logic aw,
        input logic bw, input logic [2:0] aop, input logic [1:0] bsel,
        input logic accw, input logic flw, input logic marw, input logic mdrw,
        input logic mreq, input logic ramw, input logic rfw, input logic rfs,
        input logic hlt);
        return {pcw, pcs, irw, aw, bw, aop, bsel, accw, flw, marw, mdrw,
                mreq, ramw, rfw, rfs, hlt};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs for the cycle are already driven (at the negedge); check then
    // advance to the next negedge.
    task automatic cyc(input string tag, input state_e est, input logic [19:0] eo);
        #1;
        check({tag, "_state"}, 32'(state), 32'(est));
        check({tag, "_outs"}, 32'(obs), 32'(eo));
        check({tag, "_excl"}, 32'(int'(rf_we) + int'(ram_we) + int'(mdr_we) <= 1), 32'd1);
        @(negedge clk);
    endtask

    logic [19:0] o_zero, o_fetch, o_dec, o_wb_acc, o_wb_mdr, o_halt;

    initial begin
        //          pcw pcs   irw aw bw aop   bsel  acc fl mar mdr req ram rf rfs hlt
        o_zero   = '0;
        o_fetch  = ov(1, 2'd0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        o_dec    = ov(0, 2'd0, 0, 1, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        o_wb_acc = ov(0, 2'd0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        o_wb_mdr = ov(0, 2'd0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        o_halt   = ov(0, 2'd0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // reset applied on the first posedge
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        cyc("reset_idle", ST_IDLE, o_zero);
        run = 1'b0;

        // ADD 0x1298; opcode changed after DECODE must not matter
        opcode = 4'h1;
        cyc("add_fetch", ST_FETCH, o_fetch);
        cyc("add_dec", ST_DECODE, o_dec);
        opcode = 4'hF;
        cyc("add_exec", ST_EXEC, ov(0, 2'd0, 0, 0, 0, 3'd0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        cyc("add_wb", ST_WB, o_wb_acc);

        // LD, 3 wait cycles; mem_ready high in EXEC is ignored
        opcode = 4'h7;
        cyc("ld_fetch", ST_FETCH, o_fetch);
        cyc("ld_dec", ST_DECODE, o_dec);
        mem_ready = 1'b1;
        cyc("ld_exec", ST_EXEC, ov(0, 2'd0, 0, 0, 0, 3'd0, 2'd1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc($sformatf("ld_wait%0d", i), ST_MEM,
                ov(0, 2'd0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        mem_ready = 1'b1;
        cyc("ld_ready", ST_MEM, ov(0, 2'd0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        mem_ready = 1'b0;
        cyc("ld_wb", ST_WB, o_wb_mdr);

        // ST zero wait
        opcode = 4'h8;
        cyc("st_fetch", ST_FETCH, o_fetch);
        cyc("st_dec", ST_DECODE, o_dec);
        cyc("st_exec", ST_EXEC, ov(0, 2'd0, 0, 0, 0, 3'd0, 2'd1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        mem_ready = 1'b1;
        cyc("st_mem", ST_MEM, ov(0, 2'd0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        mem_ready = 1'b0;

        // BEQ taken
        opcode = 4'h9;
        cyc("beq1_fetch", ST_FETCH, o_fetch);
        cyc("beq1_dec", ST_DECODE, o_dec);
        cyc("beq1_exec", ST_EXEC, ov(0, 2'd0, 0, 0, 0, 3'd1, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        flag_z = 1'b1;
        cyc("beq1_br", ST_BRANCH, ov(1, 2'd1, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        flag_z = 1'b0;

        // BEQ not taken
        cyc("beq0_fetch", ST_FETCH, o_fetch);
        cyc("beq0_dec", ST_DECODE, o_dec);
        cyc("beq0_exec", ST_EXEC, ov(0, 2'd0, 0, 0, 0, 3'd1, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("beq0_pc_we", 32'(pc_we), 32'd0);
        check("beq0_state", 32'(state), 32'(ST_BRANCH));
        @(negedge clk);

        // JMP
        opcode = 4'hA;
        cyc("jmp_fetch", ST_FETCH, o_fetch);
        cyc("jmp_dec", ST_DECODE, o_dec);
        cyc("jmp_exec", ST_EXEC, ov(1, 2'd2, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // ADDI
        opcode = 4'h5;
        cyc("addi_fetch", ST_FETCH, o_fetch);
        cyc("addi_dec", ST_DECODE, o_dec);
        cyc("addi_exec", ST_EXEC, ov(0, 2'd0, 0, 0, 0, 3'd0, 2'd1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        cyc("addi_wb", ST_WB, o_wb_acc);

        // LDI
        opcode = 4'h6;
        cyc("ldi_fetch", ST_FETCH, o_fetch);
        cyc("ldi_dec", ST_DECODE, o_dec);
        cyc("ldi_exec", ST_EXEC, ov(0, 2'd0, 0, 0, 0, 3'd4, 2'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("ldi_wb", ST_WB, o_wb_acc);

        // OR and AND
        opcode = 4'h4;
        cyc("or_fetch", ST_FETCH, o_fetch);
        cyc("or_dec", ST_DECODE, o_dec);
        cyc("or_exec", ST_EXEC, ov(0, 2'd0, 0, 0, 0, 3'd3, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        cyc("or_wb", ST_WB, o_wb_acc);
        opcode = 4'h3;
        cyc("and_fetch", ST_FETCH, o_fetch);
        cyc("and_dec", ST_DECODE, o_dec);
        cyc("and_exec", ST_EXEC, ov(0, 2'd0, 0, 0, 0, 3'd2, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        cyc("and_wb", ST_WB, o_wb_acc);

        // undefined 0xC: 2-cycle NOP
        opcode = 4'hC;
        cyc("undef_fetch", ST_FETCH, o_fetch);
        cyc("undef_dec", ST_DECODE, o_dec);

        // HALT, absorbing despite run toggles
        opcode = 4'hF;
        cyc("halt_fetch", ST_FETCH, o_fetch);
        cyc("halt_dec", ST_DECODE, o_dec);
        for (int i = 0; i < 20; i++) begin
            run = i[0];
            cyc($sformatf("halt_%0d", i), ST_HALT, o_halt);
        end
        run = 1'b0;
        rst = 1'b1;
        cyc("halt_rst", ST_HALT, o_halt);
        rst = 1'b0;
        run = 1'b1;
        cyc("halt_idle", ST_IDLE, o_zero);
        run = 1'b0;

        // reset in the middle of an LD memory wait
        opcode = 4'h7;
        cyc("ldr_fetch", ST_FETCH, o_fetch);
        cyc("ldr_dec", ST_DECODE, o_dec);
        cyc("ldr_exec", ST_EXEC, ov(0, 2'd0, 0, 0, 0, 3'd0, 2'd1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        cyc("ldr_wait", ST_MEM, ov(0, 2'd0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        rst = 1'b1;
        cyc("ldr_rst", ST_MEM, ov(0, 2'd0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        rst = 1'b0;
        mem_ready = 1'b1;
        cyc("ldr_idle", ST_IDLE, o_zero);
        cyc("ldr_idle2", ST_IDLE, o_zero);
        mem_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
